// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU issue stage.
//   - funct codes FN_AND..FN_SBB (4-bit function field from decode)
//   - ALU op encodings OP_AND / OP_OR / OP_ADD (2-bit alu_op)
//   - alu_entry_t: one buffered instruction (funct, a, b, rd)
// ALU_DW / ALU_RW size the entry struct and must match the DW / RW
// parameters used on alu_issue.
package alu_pkg;

  localparam int ALU_DW = 32;
  localparam int ALU_RW = 4;

  localparam logic [3:0] FN_AND = 4'd0;
  localparam logic [3:0] FN_OR  = 4'd1;
  localparam logic [3:0] FN_ADD = 4'd2;
  localparam logic [3:0] FN_SUB = 4'd3;
  localparam logic [3:0] FN_ADC = 4'd4;
  localparam logic [3:0] FN_SBB = 4'd5;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;

  typedef struct packed {
    logic [3:0]        funct;
    logic [ALU_DW-1:0] a;
    logic [ALU_DW-1:0] b;
    logic [ALU_RW-1:0] rd;
  } alu_entry_t;

  localparam int ENTRY_W = $bits(alu_entry_t);

endpackage

// File: rtl/alu_skid_buf.sv
// alu_skid_buf: 2-entry FIFO-ordered valid/ready buffer.
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   in_valid / in_ready  upstream handshake (in_ready is a register)
//   in_data  [PW]        payload captured on an input handshake
//   out_valid/out_ready  downstream handshake
//   out_data [PW]        head entry; holds its last value when empty
// Slot 0 is always the head, so an empty buffer keeps showing the last
// issued payload and the output needs no mux.
module alu_skid_buf #(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic [1:0]    cnt_p0;
  logic [1:0]    cnt_nxt;
  logic          rdy_p0;
  logic [PW-1:0] slot0_p0;
  logic [PW-1:0] slot1_p0;
  logic          push;
  logic          pop;

  assign push = in_valid && rdy_p0;
  assign pop  = (cnt_p0 != 2'd0) && out_ready;

  always_comb begin
    cnt_nxt = cnt_p0;
    if (push && !pop)
      cnt_nxt = cnt_p0 + 2'd1;
    else if (!push && pop)
      cnt_nxt = cnt_p0 - 2'd1;
  end

  // Storage boundary: occupancy, registered ready and the two slots
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_p0   <= 2'd0;
      rdy_p0   <= 1'b0;
      slot0_p0 <= '0;
      slot1_p0 <= '0;
    end else begin
      cnt_p0 <= cnt_nxt;
      rdy_p0 <= (cnt_nxt != 2'd2);
      if (pop && cnt_p0 == 2'd2)
        slot0_p0 <= slot1_p0;
      // A push lands in the first free slot after any simultaneous pop.
      if (push) begin
        if ((cnt_p0 == 2'd0) || (cnt_p0 == 2'd1 && pop))
          slot0_p0 <= in_data;
        else
          slot1_p0 <= in_data;
      end
    end
  end

  assign in_ready  = rdy_p0;
  assign out_valid = (cnt_p0 != 2'd0);
  assign out_data  = slot0_p0;

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issue stage in front of the combinational 32-bit ALU.
// Buffers decoded instructions in a 2-entry skid buffer, decodes the head
// funct into alu_op/alu_biv/alu_cin and keeps a carry flag fed by alu_cout.
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   in_valid/in_ready                 upstream handshake
//   in_funct, in_a, in_b, in_rs1/2, in_rd   decoded instruction
//   out_valid/out_ready               handshake with writeback
//   alu_a, alu_b, alu_op, alu_biv, alu_cin  ALU control and operands
//   alu_cout                          ALU carry out (combinational)
//   out_rd, out_illegal, carry_flag   head rd, undefined funct, carry flag
//   wb_valid, wb_rd, wb_data          writeback bypass
// Optional feature: define ALU_ISSUE_FWD_EN to bypass writeback data into
// captured operands; otherwise the wb_* ports are ignored.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_funct,
  input  logic [DW-1:0] in_a,
  input  logic [DW-1:0] in_b,
  input  logic [RW-1:0] in_rs1,
  input  logic [RW-1:0] in_rs2,
  input  logic [RW-1:0] in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_op,
  output logic          alu_biv,
  output logic          alu_cin,
  input  logic          alu_cout,
  output logic [RW-1:0] out_rd,
  output logic          out_illegal,
  output logic          carry_flag,
  input  logic          wb_valid,
  input  logic [RW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data
);

  alu_entry_t cap_p0;
  alu_entry_t head_p1;
  logic       vld_p1;
  logic       carry_p1;

  always_comb begin
    cap_p0       = '0;
    cap_p0.funct = in_funct;
    cap_p0.a     = in_a;
    cap_p0.b     = in_b;
    cap_p0.rd    = in_rd;
`ifdef ALU_ISSUE_FWD_EN
    // Register 0 is never a bypass source.
    if (wb_valid && (wb_rd != '0) && (wb_rd == in_rs1))
      cap_p0.a = wb_data;
    if (wb_valid && (wb_rd != '0) && (wb_rd == in_rs2))
      cap_p0.b = wb_data;
`endif
  end

`ifndef ALU_ISSUE_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{wb_valid, wb_rd, wb_data, in_rs1, in_rs2};
`endif

  // Capture -> buffer head boundary
  alu_skid_buf #(.PW(ENTRY_W)) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (cap_p0),
    .out_valid(vld_p1),
    .out_ready(out_ready),
    .out_data (head_p1)
  );

  // Carry is read at the head, so an ADC right behind an ADD sees the
  // flag written by that ADD's handshake.
  always_comb begin
    alu_op      = OP_AND;
    alu_biv     = 1'b0;
    alu_cin     = 1'b0;
    out_illegal = 1'b0;
    case (head_p1.funct)
      FN_AND: alu_op = OP_AND;
      FN_OR:  alu_op = OP_OR;
      FN_ADD: alu_op = OP_ADD;
      FN_SUB: begin alu_op = OP_ADD; alu_biv = 1'b1; alu_cin = 1'b1;     end
      FN_ADC: begin alu_op = OP_ADD;                 alu_cin = carry_p1; end
      FN_SBB: begin alu_op = OP_ADD; alu_biv = 1'b1; alu_cin = carry_p1; end
      default: out_illegal = 1'b1;
    endcase
  end

  // Carry flag boundary: only arithmetic codes 2..5 update it
  always_ff @(posedge clk) begin
    if (!rst_n)
      carry_p1 <= 1'b0;
    else if (vld_p1 && out_ready && (alu_op == OP_ADD))
      carry_p1 <= alu_cout;
  end

  assign out_valid  = vld_p1;
  assign alu_a      = head_p1.a;
  assign alu_b      = head_p1.b;
  assign out_rd     = head_p1.rd;
  assign carry_flag = carry_p1;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_funct;
  logic [31:0] in_a, in_b;
  logic [3:0]  in_rs1, in_rs2, in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic        alu_biv, alu_cin, alu_cout;
  logic [3:0]  out_rd;
  logic        out_illegal, carry_flag;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue #(.DW(32), .RW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_a(in_a), .in_b(in_b), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_biv(alu_biv),
    .alu_cin(alu_cin), .alu_cout(alu_cout), .out_rd(out_rd),
    .out_illegal(out_illegal), .carry_flag(carry_flag),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  // Behavioural ALU model driving alu_cout.
  logic [32:0] sum;
  logic [31:0] res;
  always_comb begin
    sum = {1'b0, alu_a} + {1'b0, (alu_biv ? ~alu_b : alu_b)} + {32'b0, alu_cin};
    res = 32'h0;
    alu_cout = 1'b0;
    case (alu_op)
      2'b00: res = alu_a & alu_b;
      2'b01: res = alu_a | alu_b;
      default: begin res = sum[31:0]; alu_cout = sum[32]; end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] rd);
    in_valid = 1'b1; in_funct = f; in_a = a; in_b = b; in_rd = rd;
    in_rs1 = 4'd0; in_rs2 = 4'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if ({alu_a, alu_b} !== 64'h0) begin errors++; $display("FAIL rst_operands: got %h %h want 0 0", alu_a, alu_b); end
    checks++; if ({alu_op, alu_biv, alu_cin} !== 4'b0) begin errors++; $display("FAIL rst_ctrl: got %b want 0000", {alu_op, alu_biv, alu_cin}); end
    checks++; if ({out_rd, out_illegal, carry_flag} !== 6'b0) begin errors++; $display("FAIL rst_misc: got %b want 000000", {out_rd, out_illegal, carry_flag}); end
    rst_n = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    push(4'd3, 32'd5, 32'd7, 4'd2);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid: got %b want 1", out_valid); end
    checks++; if ({alu_op, alu_biv, alu_cin} !== 4'b1011) begin errors++; $display("FAIL sub_ctrl: got %b want 1011", {alu_op, alu_biv, alu_cin}); end
    checks++; if (res !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_result: got %h want fffffffe", res); end
    checks++; if (out_rd !== 4'd2) begin errors++; $display("FAIL sub_rd: got %0d want 2", out_rd); end
    step();
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL sub_carry: got %b want 0", carry_flag); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_empty: got %b want 0", out_valid); end
    checks++; if (alu_a !== 32'd5) begin errors++; $display("FAIL sub_hold: got %h want 5", alu_a); end
  endtask

  task automatic test_carry_chain();
    out_ready = 1'b1;
    push(4'd2, 32'hFFFFFFFF, 32'd1, 4'd1);
    step();
    checks++; if (alu_cout !== 1'b1) begin errors++; $display("FAIL chain_add_cout: got %b want 1", alu_cout); end
    push(4'd4, 32'd0, 32'd0, 4'd4);
    step();
    in_valid = 1'b0;
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL chain_carry: got %b want 1", carry_flag); end
    checks++; if (alu_cin !== 1'b1) begin errors++; $display("FAIL chain_adc_cin: got %b want 1", alu_cin); end
    checks++; if (res !== 32'd1) begin errors++; $display("FAIL chain_adc_res: got %h want 1", res); end
    checks++; if (out_rd !== 4'd4 || out_valid !== 1'b1) begin errors++; $display("FAIL chain_adc_head: got rd %0d v %b want 4 1", out_rd, out_valid); end
    step();
    checks++; if (carry_flag !== 1'b0) begin errors++; $display("FAIL chain_carry_clr: got %b want 0", carry_flag); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    push(4'd2, 32'hFFFFFFFF, 32'd1, 4'd1);
    step();
    in_valid = 1'b0;
    step();
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL ill_pre_carry: got %b want 1", carry_flag); end
    push(4'd9, 32'd3, 32'd3, 4'd5);
    step();
    in_valid = 1'b0;
    checks++; if (out_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b want 1", out_illegal); end
    checks++; if ({alu_op, alu_biv, alu_cin} !== 4'b0000) begin errors++; $display("FAIL ill_ctrl: got %b want 0000", {alu_op, alu_biv, alu_cin}); end
    checks++; if (out_valid !== 1'b1 || out_rd !== 4'd5) begin errors++; $display("FAIL ill_issue: got v %b rd %0d want 1 5", out_valid, out_rd); end
    step();
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL ill_carry: got %b want 1", carry_flag); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push(4'd0, 32'd1, 32'd1, 4'd1);
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_one: got rdy %b v %b want 1 1", in_ready, out_valid); end
    push(4'd0, 32'd2, 32'd2, 4'd2);
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b want 0", in_ready); end
    push(4'd0, 32'd3, 32'd3, 4'd3);
    step();
    checks++; if (in_ready !== 1'b0 || out_rd !== 4'd1) begin errors++; $display("FAIL bp_hold: got rdy %b rd %0d want 0 1", in_ready, out_rd); end
    out_ready = 1'b1;
    step();
    checks++; if (out_rd !== 4'd2 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_pop1: got rd %0d rdy %b want 2 1", out_rd, in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_rd !== 4'd3 || alu_a !== 32'd3 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_pop2: got rd %0d a %h v %b want 3 3 1", out_rd, alu_a, out_valid); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_fwd();
    logic [31:0] exp_a;
    out_ready = 1'b1;
`ifdef ALU_ISSUE_FWD_EN
    exp_a = 32'h1234;
`else
    exp_a = 32'h0;
`endif
    push(4'd0, 32'd0, 32'hFFFF, 4'd6);
    in_rs1 = 4'd3; in_rs2 = 4'd3;
    wb_valid = 1'b1; wb_rd = 4'd3; wb_data = 32'h1234;
    step();
    in_valid = 1'b0; wb_valid = 1'b0;
    checks++; if (alu_a !== exp_a) begin errors++; $display("FAIL fwd_a: got %h want %h", alu_a, exp_a); end
`ifdef ALU_ISSUE_FWD_EN
    checks++; if (alu_b !== 32'h1234) begin errors++; $display("FAIL fwd_b: got %h want 1234", alu_b); end
`else
    checks++; if (alu_b !== 32'hFFFF) begin errors++; $display("FAIL fwd_b_off: got %h want ffff", alu_b); end
`endif
    step();
    push(4'd0, 32'd0, 32'd0, 4'd7);
    wb_valid = 1'b1; wb_rd = 4'd0; wb_data = 32'h1234;
    step();
    in_valid = 1'b0; wb_valid = 1'b0;
    checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL fwd_r0: got %h want 0", alu_a); end
    step();
  endtask

  task automatic test_reset_mid();
    checks++; if (carry_flag !== 1'b1) begin errors++; $display("FAIL mid_pre_carry: got %b want 1", carry_flag); end
    out_ready = 1'b0;
    push(4'd0, 32'hA, 32'hB, 4'd9);
    step();
    push(4'd0, 32'hC, 32'hD, 4'd10);
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0 || carry_flag !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst: got v %b c %b rdy %b want 0 0 0", out_valid, carry_flag, in_ready); end
    checks++; if (alu_a !== 32'h0 || out_rd !== 4'd0) begin errors++; $display("FAIL mid_rst_data: got a %h rd %0d want 0 0", alu_a, out_rd); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_rel: got rdy %b v %b want 1 0", in_ready, out_valid); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_funct = 4'd0; in_a = 32'd0; in_b = 32'd0;
    in_rs1 = 4'd0; in_rs2 = 4'd0; in_rd = 4'd0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = 4'd0; wb_data = 32'd0;
    test_reset();
    test_sub();
    test_carry_chain();
    test_illegal();
    test_backpressure();
    test_fwd();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
